// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b MEM stage: memory-op encoding and access FSM states.
package mem_access_unit_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned DEST_W = 3;

    typedef enum logic [2:0] {
        MOP_NONE = 3'd0,
        MOP_LD   = 3'd1,
        MOP_ST   = 3'd2,
        MOP_LDI  = 3'd3,
        MOP_STI  = 3'd4
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_PTR  = 2'd1,
        MS_DATA = 2'd2,
        MS_HOLD = 2'd3
    } lc3b_mem_state;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for LDB/STB: store replication, lane enables, load select + sign-extend.
module byte_lane_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             byte_mode,
    input  logic             addr_lsb,
    input  logic [WIDTH-1:0] sr_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] wdata,
    output logic [1:0]       byte_enable,
    output logic [WIDTH-1:0] load_data
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [HALF-1:0] lane;

    always_comb begin
        lane        = '0;
        wdata       = sr_data;
        byte_enable = 2'b11;
        load_data   = rdata;
        if (byte_mode) begin
            lane        = addr_lsb ? rdata[WIDTH-1:HALF] : rdata[HALF-1:0];
            wdata       = {sr_data[HALF-1:0], sr_data[HALF-1:0]};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            load_data   = {{HALF{lane[HALF-1]}}, lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM stage: sequences dcache accesses for LD/ST and the two-access LDI/STI,
// stalls the pipe while an access is outstanding and produces the writeback payload.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_mem_op,
    input  logic             in_byte,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_sr_data,
    input  logic [WIDTH-1:0] in_alu,
    input  logic [2:0]       in_dest,
    input  logic             flush,
    input  logic             load_mem_wb,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [WIDTH-1:0] dmem_address,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output logic             mem_stall,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       wb_dest,
    output logic             wb_is_nop
);

    lc3b_mem_state state_q, state_d;
    lc3b_mem_op    op;

    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] addr_q, sr_q, alu_q;
    logic [2:0]       dest_q;
    logic             is_sti_q;
    logic             cancel_q, cancel_d;
    logic [WIDTH-1:0] hold_data_q;
    logic [2:0]       hold_dest_q;
    logic             hold_nop_q;
    logic             ctx_load, hold_load;
    logic             mem_req;
    logic             lane_byte;
    logic [WIDTH-1:0] lane_wdata, lane_load;
    logic [1:0]       lane_be;

    assign op      = lc3b_mem_op'(in_mem_op);
    assign mem_req = in_valid & ~flush & (op != MOP_NONE);

    // Sub-word steering only applies to the single-access LD/ST issued from IDLE.
    assign lane_byte = (state_q == MS_IDLE) & in_byte & ((op == MOP_LD) | (op == MOP_ST));

    byte_lane_unit #(.WIDTH(WIDTH)) u_byte_lane (
        .byte_mode   (lane_byte),
        .addr_lsb    (in_addr[0]),
        .sr_data     (in_sr_data),
        .rdata       (dmem_rdata),
        .wdata       (lane_wdata),
        .byte_enable (lane_be),
        .load_data   (lane_load)
    );

    // Next-state, dcache request and writeback selection.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        cancel_d         = cancel_q;
        ctx_load         = 1'b0;
        hold_load        = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = {in_addr[WIDTH-1:1], 1'b0};
        dmem_wdata       = lane_wdata;
        dmem_byte_enable = lane_be;
        mem_stall        = 1'b0;
        wb_data          = in_alu;
        wb_dest          = in_dest;
        wb_is_nop        = ~in_valid | flush;

        if (reset) begin
            wb_data   = '0;
            wb_is_nop = 1'b1;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (mem_req) begin
                        case (op)
                            MOP_LD, MOP_ST: begin
                                dmem_read  = (op == MOP_LD);
                                dmem_write = (op == MOP_ST);
                                if (op == MOP_LD) wb_data = lane_load;
                                mem_stall  = ~dmem_resp;
                                if (dmem_resp && !load_mem_wb) begin
                                    state_d   = MS_HOLD;
                                    hold_load = 1'b1;
                                end
                            end
                            MOP_LDI, MOP_STI: begin
                                dmem_read = 1'b1;
                                mem_stall = 1'b1;
                                ctx_load  = 1'b1;
                                cancel_d  = 1'b0;
                                // A same-cycle pointer response skips PTR entirely.
                                if (dmem_resp) begin
                                    ptr_d   = dmem_rdata;
                                    state_d = MS_DATA;
                                end else begin
                                    state_d = MS_PTR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                MS_PTR: begin
                    dmem_read        = 1'b1;
                    dmem_address     = {addr_q[WIDTH-1:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                    wb_data          = alu_q;
                    wb_dest          = dest_q;
                    wb_is_nop        = cancel_q | flush;
                    mem_stall        = 1'b1;
                    if (flush) cancel_d = 1'b1;
                    if (dmem_resp) begin
                        if (cancel_q || flush) begin
                            state_d   = MS_IDLE;
                            cancel_d  = 1'b0;
                            mem_stall = 1'b0;
                        end else begin
                            ptr_d   = dmem_rdata;
                            state_d = MS_DATA;
                        end
                    end
                end

                MS_DATA: begin
                    dmem_read        = ~is_sti_q;
                    dmem_write       = is_sti_q;
                    dmem_address     = {ptr_q[WIDTH-1:1], 1'b0};
                    dmem_wdata       = sr_q;
                    dmem_byte_enable = 2'b11;
                    wb_data          = is_sti_q ? alu_q : dmem_rdata;
                    wb_dest          = dest_q;
                    wb_is_nop        = cancel_q | flush;
                    mem_stall        = ~dmem_resp;
                    if (flush) cancel_d = 1'b1;
                    if (dmem_resp) begin
                        if (cancel_q || flush) begin
                            state_d  = MS_IDLE;
                            cancel_d = 1'b0;
                        end else if (load_mem_wb) begin
                            state_d = MS_IDLE;
                        end else begin
                            state_d   = MS_HOLD;
                            hold_load = 1'b1;
                        end
                    end
                end

                MS_HOLD: begin
                    wb_data   = hold_data_q;
                    wb_dest   = hold_dest_q;
                    wb_is_nop = hold_nop_q | flush;
                    mem_stall = ~load_mem_wb;
                    if (load_mem_wb) state_d = MS_IDLE;
                end

                default: state_d = MS_IDLE;
            endcase
        end
    end

    // State, indirect-op context and parked result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MS_IDLE;
            ptr_q       <= '0;
            addr_q      <= '0;
            sr_q        <= '0;
            alu_q       <= '0;
            dest_q      <= '0;
            is_sti_q    <= 1'b0;
            cancel_q    <= 1'b0;
            hold_data_q <= '0;
            hold_dest_q <= '0;
            hold_nop_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cancel_q <= cancel_d;
            if (ctx_load) begin
                addr_q   <= in_addr;
                sr_q     <= in_sr_data;
                alu_q    <= in_alu;
                dest_q   <= in_dest;
                is_sti_q <= (op == MOP_STI);
            end
            if (hold_load) begin
                hold_data_q <= wb_data;
                hold_dest_q <= wb_dest;
                hold_nop_q  <= wb_is_nop;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [2:0]   in_mem_op;
    logic         in_byte;
    logic [W-1:0] in_addr, in_sr_data, in_alu;
    logic [2:0]   in_dest;
    logic         flush, load_mem_wb;
    logic         dmem_read, dmem_write;
    logic [W-1:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [1:0]   dmem_byte_enable;
    logic         dmem_resp;
    logic         mem_stall;
    logic [W-1:0] wb_data;
    logic [2:0]   wb_dest;
    logic         wb_is_nop;

    always #5 clk = ~clk;

    mem_access_unit #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_mem_op        (in_mem_op),
        .in_byte          (in_byte),
        .in_addr          (in_addr),
        .in_sr_data       (in_sr_data),
        .in_alu           (in_alu),
        .in_dest          (in_dest),
        .flush            (flush),
        .load_mem_wb      (load_mem_wb),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_stall        (mem_stall),
        .wb_data          (wb_data),
        .wb_dest          (wb_dest),
        .wb_is_nop        (wb_is_nop)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   dest;
        logic         nop;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic [2:0] dst, input logic n);
        exp_t e;
        e.data = d;
        e.dest = dst;
        e.nop  = n;
        sb.push_back(e);
    endtask

    // Compare the writeback payload against the scoreboard head; pop when retired.
    task automatic check_wb(input string tag, input logic pop);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb[0];
            chk({tag, "_wb_data"}, wb_data, e.data);
            chk({tag, "_wb_dest"}, 16'(wb_dest), 16'(e.dest));
            chk({tag, "_wb_nop"}, 16'(wb_is_nop), 16'(e.nop));
            if (pop) void'(sb.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_read"}, 16'(dmem_read), 16'd0);
        chk({tag, "_write"}, 16'(dmem_write), 16'd0);
        chk({tag, "_stall"}, 16'(mem_stall), 16'd0);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_mem_op   = MOP_NONE;
        in_byte     = 1'b0;
        in_addr     = '0;
        in_sr_data  = '0;
        in_alu      = '0;
        in_dest     = '0;
        flush       = 1'b0;
        load_mem_wb = 1'b1;
        dmem_rdata  = '0;
        dmem_resp   = 1'b0;

        // Reset state
        tick();
        settle();
        check_idle("rst");
        chk("rst_nop", 16'(wb_is_nop), 16'd1);
        chk("rst_wb_data", wb_data, 16'h0000);
        tick();
        reset = 1'b0;
        settle();
        check_idle("post_rst");

        // LDR with same-cycle response
        tick();
        in_valid = 1'b1; in_mem_op = MOP_LD; in_byte = 1'b0; in_addr = 16'h3001;
        in_alu = 16'h1111; in_dest = 3'd5; dmem_rdata = 16'hBEEF; dmem_resp = 1'b1;
        push_exp(16'hBEEF, 3'd5, 1'b0);
        settle();
        chk("ldr_read", 16'(dmem_read), 16'd1);
        chk("ldr_addr", dmem_address, 16'h3000);
        chk("ldr_be", 16'(dmem_byte_enable), 16'h3);
        chk("ldr_stall", 16'(mem_stall), 16'd0);
        check_wb("ldr", 1'b1);

        // LDB from odd address, response after three waiting cycles
        tick();
        in_mem_op = MOP_LD; in_byte = 1'b1; in_addr = 16'h3001; in_dest = 3'd2;
        dmem_resp = 1'b0; dmem_rdata = 16'h0000;
        push_exp(16'hFF80, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ldb_wait_stall", 16'(mem_stall), 16'd1);
            chk("ldb_wait_read", 16'(dmem_read), 16'd1);
            chk("ldb_wait_addr", dmem_address, 16'h3000);
            chk("ldb_wait_be", 16'(dmem_byte_enable), 16'h2);
            tick();
        end
        dmem_resp = 1'b1; dmem_rdata = 16'h80FF;
        settle();
        chk("ldb_done_stall", 16'(mem_stall), 16'd0);
        check_wb("ldb", 1'b1);

        // STB to even address
        tick();
        in_mem_op = MOP_ST; in_byte = 1'b1; in_addr = 16'h2000; in_sr_data = 16'h1234;
        in_alu = 16'hABCD; in_dest = 3'd1; dmem_resp = 1'b1;
        push_exp(16'hABCD, 3'd1, 1'b0);
        settle();
        chk("stb_write", 16'(dmem_write), 16'd1);
        chk("stb_read", 16'(dmem_read), 16'd0);
        chk("stb_wdata", dmem_wdata, 16'h3434);
        chk("stb_be", 16'(dmem_byte_enable), 16'h1);
        chk("stb_stall", 16'(mem_stall), 16'd0);
        check_wb("stb", 1'b1);

        // Flush in IDLE suppresses the request
        tick();
        in_mem_op = MOP_LD; in_byte = 1'b0; in_addr = 16'h0100; flush = 1'b1; dmem_resp = 1'b0;
        settle();
        check_idle("flush_idle");
        chk("flush_idle_nop", 16'(wb_is_nop), 16'd1);

        // LDI through PTR and DATA
        tick();
        flush = 1'b0;
        in_mem_op = MOP_LDI; in_byte = 1'b0; in_addr = 16'h4000; in_dest = 3'd3;
        in_alu = 16'h0042; dmem_resp = 1'b0;
        push_exp(16'h00A5, 3'd3, 1'b0);
        settle();
        chk("ldi_req_read", 16'(dmem_read), 16'd1);
        chk("ldi_req_addr", dmem_address, 16'h4000);
        chk("ldi_req_stall", 16'(mem_stall), 16'd1);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 16'h5002;
        settle();
        chk("ldi_ptr_read", 16'(dmem_read), 16'd1);
        chk("ldi_ptr_addr", dmem_address, 16'h4000);
        chk("ldi_ptr_stall", 16'(mem_stall), 16'd1);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 16'h0000;
        settle();
        chk("ldi_data_read", 16'(dmem_read), 16'd1);
        chk("ldi_data_addr", dmem_address, 16'h5002);
        chk("ldi_data_stall", 16'(mem_stall), 16'd1);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 16'h00A5;
        settle();
        chk("ldi_done_stall", 16'(mem_stall), 16'd0);
        check_wb("ldi", 1'b1);
        tick();
        in_valid = 1'b0; in_mem_op = MOP_NONE; dmem_resp = 1'b0;
        settle();
        check_idle("ldi_after");

        // STI with flush arriving while the second write waits
        tick();
        in_valid = 1'b1; in_mem_op = MOP_STI; in_addr = 16'h4100; in_sr_data = 16'h7777;
        in_alu = 16'h0099; in_dest = 3'd4; dmem_resp = 1'b0;
        push_exp(16'h0099, 3'd4, 1'b1);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 16'h6000;
        settle();
        chk("sti_ptr_read", 16'(dmem_read), 16'd1);
        tick();
        dmem_resp = 1'b0; flush = 1'b1;
        settle();
        chk("sti_data_write", 16'(dmem_write), 16'd1);
        chk("sti_data_addr", dmem_address, 16'h6000);
        chk("sti_data_wdata", dmem_wdata, 16'h7777);
        chk("sti_data_stall", 16'(mem_stall), 16'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0; in_mem_op = MOP_NONE;
        settle();
        chk("sti_held_write", 16'(dmem_write), 16'd1);
        chk("sti_held_addr", dmem_address, 16'h6000);
        tick();
        dmem_resp = 1'b1;
        settle();
        chk("sti_done_write", 16'(dmem_write), 16'd1);
        chk("sti_done_stall", 16'(mem_stall), 16'd0);
        check_wb("sti_flush", 1'b1);
        tick();
        dmem_resp = 1'b0;
        settle();
        check_idle("sti_after");

        // LDR completing with load_mem_wb low parks in HOLD
        tick();
        in_valid = 1'b1; in_mem_op = MOP_LD; in_byte = 1'b0; in_addr = 16'h1234;
        in_dest = 3'd6; in_alu = 16'h0000; dmem_rdata = 16'hCAFE; dmem_resp = 1'b1;
        load_mem_wb = 1'b0;
        push_exp(16'hCAFE, 3'd6, 1'b0);
        settle();
        chk("hold_done_stall", 16'(mem_stall), 16'd0);
        check_wb("hold_done", 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            in_mem_op = MOP_ST; in_addr = 16'h5555; in_dest = 3'd0;
            dmem_rdata = 16'h0000; dmem_resp = 1'b0;
            settle();
            chk("hold_no_read", 16'(dmem_read), 16'd0);
            chk("hold_no_write", 16'(dmem_write), 16'd0);
            chk("hold_stall", 16'(mem_stall), 16'd1);
            check_wb("hold_wait", 1'b0);
        end
        tick();
        in_valid = 1'b0; in_mem_op = MOP_NONE; load_mem_wb = 1'b1;
        settle();
        chk("hold_release_stall", 16'(mem_stall), 16'd0);
        check_wb("hold_release", 1'b1);
        tick();
        in_alu = 16'h0077;
        settle();
        check_idle("hold_after");
        chk("hold_after_nop", 16'(wb_is_nop), 16'd1);
        chk("hold_after_data", wb_data, 16'h0077);

        // Reset while in PTR
        tick();
        in_valid = 1'b1; in_mem_op = MOP_LDI; in_addr = 16'h4200; dmem_resp = 1'b0;
        tick();
        settle();
        chk("rptr_read", 16'(dmem_read), 16'd1);
        chk("rptr_addr", dmem_address, 16'h4200);
        tick();
        reset = 1'b1; in_valid = 1'b0; in_mem_op = MOP_NONE;
        tick();
        reset = 1'b0;
        settle();
        check_idle("rptr_after");
        chk("rptr_after_nop", 16'(wb_is_nop), 16'd1);

        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage datapath/control of the pipelined LC-3b; sits between the EX/MEM state register and mem_wb_state_reg.
- Sequences data-memory accesses for LDR/LDB/STR/STB and the two-access indirect ops LDI/STI over a request/response dcache port.
- Produces the writeback word, dest, and nop flag that feed mem_wb_state_reg, and stalls the pipeline while an access is outstanding.

Parameters:
- WIDTH, 16, data/address width (lc3b_word).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM holds a real (non-nop) instruction
- in_mem_op  in  3  lc3b_mem_op: MOP_NONE, MOP_LD, MOP_ST, MOP_LDI, MOP_STI
- in_byte  in  1  byte access (LDB/STB); ignored for LDI/STI
- in_addr  in  WIDTH  effective address from EX
- in_sr_data  in  WIDTH  store source register value
- in_alu  in  WIDTH  ALU/PC result for non-memory ops
- in_dest  in  3  destination register
- flush  in  1  squash the instruction in MEM
- load_mem_wb  in  1  downstream register accepts this cycle
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  WIDTH  access address, bit 0 forced 0
- dmem_wdata  out  WIDTH  write data
- dmem_byte_enable  out  2  byte lanes
- dmem_rdata  in  WIDTH  read data
- dmem_resp  in  1  access complete, same cycle as data
- mem_stall  out  1  freeze IF..MEM this cycle
- wb_data  out  WIDTH  to mem_wb_regfile_in
- wb_dest  out  3  to mem_wb_dest_in
- wb_is_nop  out  1  to mem_wb_is_nop_in

Behaviour:
- Reset: state IDLE, pointer/result registers 0.
- Reset outputs: dmem_read=0, dmem_write=0, mem_stall=0, wb_is_nop=1, wb_data=0.
- FSM states:
  - IDLE: no access in flight. Requests are combinational from inputs, so a 1-cycle response gives zero-bubble completion.
  - PTR: first read of LDI/STI.
  - DATA: second access of LDI/STI.
  - HOLD: result complete but load_mem_wb=0.
- IDLE behaviour:
  - in_valid=0 or MOP_NONE: wb_data=in_alu, no request, mem_stall=0.
  - MOP_LD: dmem_read=1. MOP_ST: dmem_write=1. MOP_LDI/MOP_STI: dmem_read=1 word access, then go to PTR.
  - LD/ST with dmem_resp=1: done this cycle.
  - LD/ST with dmem_resp=0: stay, mem_stall=1, request held. Address, data, and enables must be stable until resp.
- PTR: hold read at in_addr. On resp, latch ptr=dmem_rdata and go to DATA. No extra bubble; DATA issues next cycle.
- DATA: access ptr; read for LDI, write in_sr_data for STI. On resp, done.
- Done handling:
  - If load_mem_wb=1, return to IDLE.
  - Else latch the result and go to HOLD. HOLD issues no requests and presents the latched result until load_mem_wb=1.
- mem_stall: 1 whenever the state is not IDLE, or IDLE with a memory op and no resp. It is deasserted in the completion cycle.
- Width rules:
  - Word access: byte_enable=11; wdata=in_sr_data.
  - STB: wdata={sr[7:0],sr[7:0]}; byte_enable=addr[0]?10:01.
  - LDB: wb_data=sign-extend(rdata[addr[0]?15:8 : 7:0]).
  - LD/LDI: wb_data=rdata. ST/STI: wb_data=in_alu.
- wb_dest=in_dest (latched in PTR/DATA/HOLD).
- wb_is_nop=~in_valid | flush | cancelled.
- Flush rules:
  - Flush in IDLE before resp: no request issued that cycle; wb_is_nop=1.
  - Flush in PTR/DATA: the outstanding request stays asserted until resp (the cache cannot abandon it). A pending STI second write is not issued. The result is marked cancelled and forces wb_is_nop=1; state returns to IDLE.
- Reset mid-access: IDLE next edge; requests drop. The cache tolerates an abandoned request.
- Simultaneous resp + flush in the same cycle: the access counts as complete, and the result is squashed.

Decomposition:
- lc3b_types package additions: lc3b_mem_op enum, lc3b_mem_state enum.
- Sub-module byte_lane_unit (combinational): STB data replication, byte enable, LDB select and sign-extend. The FSM stays in mem_access_unit.

Test Plan:
- LDR, addr=0x3001, rdata=0xBEEF, resp the same cycle: dmem_address=0x3000, byte_enable=11, wb_data=0xBEEF, mem_stall never 1.
- LDB from 0x3001 with rdata=0x80FF and resp after 3 cycles: mem_stall=1 for 3 cycles, request stable throughout, wb_data=0xFF80.
- STB, addr=0x2000, sr=0x1234: wdata=0x3434, byte_enable=01, wb_data=in_alu.
- LDI, addr=0x4000: first read returns 0x5002, then read at 0x5002 returns 0x00A5. Two accesses, wb_data=0x00A5, mem_stall high until the second resp.
- STI with flush asserted in DATA while the write is waiting: write held until resp, wb_is_nop=1 after completion, FSM returns to IDLE.
- Done with load_mem_wb=0 for 2 cycles: HOLD with wb_data stable and no new requests. Then load_mem_wb=1 returns to IDLE. Reset in PTR: dmem_read=0 and wb_is_nop=1 next cycle.
